ro_freq_counter: RTL and testbench

Measurement front end for the LUT ring oscillators in the delay-based PUF. It enables one oscillator, waits for the ring to settle, and counts the oscillator's rising edges over a fixed window of system clocks. It returns the count through a start/done handshake. One instance sits between each oscillator (or oscillator mux output) and the PUF response-comparison logic.

---
 rtl/ro_freq_counter.sv | 115 +++++++++++
 tb/tb_ro_freq_counter.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/ro_freq_counter.sv
// Ring-oscillator edge counter: enables one ring, lets it settle,
// then counts synchronized rising edges over a fixed clk window.
`timescale 1ns/1ps
module ro_freq_counter #(
    parameter int WINDOW_CYCLES = 1024,
    parameter int SETTLE_CYCLES = 16,
    parameter int SYNC_STAGES   = 2,
    parameter int COUNT_W       = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               ro_in,
    output logic               ro_enable,
    output logic               busy,
    output logic               done,
    output logic [COUNT_W-1:0] count,
    output logic               overflow
);

    localparam int TMAX = (WINDOW_CYCLES > SETTLE_CYCLES) ?
                          WINDOW_CYCLES : SETTLE_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        COUNT,
        DONE
    } state_t;

    state_t             state, nxt;
    logic [TW-1:0]      tmr, tmr_d;
    logic [COUNT_W-1:0] cnt, cnt_d;
    logic               ovf, ovf_d;
    logic [SYNC_STAGES-1:0] sync;
    logic               prev;
    logic               rise;

    assign rise = sync[SYNC_STAGES-1] & ~prev;

    always_comb begin
        nxt   = state;
        tmr_d = tmr;
        cnt_d = cnt;
        ovf_d = ovf;
        unique case (state)
            IDLE: begin
                if (start) begin
                    nxt   = SETTLE;
                    tmr_d = TW'(SETTLE_CYCLES - 1);
                    cnt_d = '0;
                    ovf_d = 1'b0;
                end
            end
            SETTLE: begin
                if (tmr == '0) begin
                    nxt   = COUNT;
                    tmr_d = TW'(WINDOW_CYCLES - 1);
                end else begin
                    tmr_d = tmr - 1'b1;
                end
            end
            COUNT: begin
                // Saturate rather than wrap; a lost edge is flagged instead.
                if (rise) begin
                    if (&cnt) ovf_d = 1'b1;
                    else      cnt_d = cnt + 1'b1;
                end
                if (tmr == '0) nxt = DONE;
                else           tmr_d = tmr - 1'b1;
            end
            DONE:    nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            tmr   <= '0;
            cnt   <= '0;
            ovf   <= 1'b0;
            sync  <= '0;
            prev  <= 1'b0;
        end else begin
            state <= nxt;
            tmr   <= tmr_d;
            cnt   <= cnt_d;
            ovf   <= ovf_d;
            sync  <= {sync[SYNC_STAGES-2:0], ro_in};
            prev  <= sync[SYNC_STAGES-1];
        end
    end

    // Outputs are registered from the next state so they align with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ro_enable <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            count     <= '0;
            overflow  <= 1'b0;
        end else begin
            ro_enable <= (nxt == SETTLE) || (nxt == COUNT);
            busy      <= (nxt != IDLE);
            done      <= (nxt == DONE);
            if (nxt == DONE) begin
                count    <= cnt_d;
                overflow <= ovf_d;
            end
        end
    end

endmodule

// File: tb/tb_ro_freq_counter.sv
// Directed and randomized checks of ro_freq_counter against
// an arithmetic edges-per-window model.
`timescale 1ns/1ps
module tb_ro_freq_counter;

    localparam int W  = 100;
    localparam int S  = 8;
    localparam int CW = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          ro_in;
    logic          ro_enable;
    logic          busy;
    logic          done;
    logic [CW-1:0] count;
    logic          overflow;

    int   vectors = 0;
    int   miscompares = 0;

    int   mode = 2;
    int   per = 10;
    int   ph = 0;
    logic lvl = 1'b0;
    int   cyc = 0;
    logic ro_sync = 1'b0;
    logic ro_async = 1'b0;
    real  aph;

    ro_freq_counter #(
        .WINDOW_CYCLES(W),
        .SETTLE_CYCLES(S),
        .SYNC_STAGES  (2),
        .COUNT_W      (CW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .ro_in    (ro_in),
        .ro_enable(ro_enable),
        .busy     (busy),
        .done     (done),
        .count    (count),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        ro_sync = ((cyc + ph) % per) < (per / 2);
    end

    initial begin
        aph = $urandom_range(0, 1037) / 10.0;
        #(aph);
        forever #51.85 ro_async = ~ro_async;
    end

    assign ro_in = (mode == 1) ? ro_async :
                   (mode == 2) ? lvl : ro_sync;

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic measure(input bit inj_mid, input bit inj_done,
                           output int got_cnt, output int got_ovf,
                           output int lat, output int en_cyc,
                           output int busy_cyc, output bit stable);
        logic [CW-1:0] held;
        held = count;
        lat = 0;
        en_cyc = 0;
        busy_cyc = 0;
        stable = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int n = 1; n <= 400; n++) begin
            start = inj_mid && (n == 3 || n == 50);
            en_cyc += int'(ro_enable);
            busy_cyc += int'(busy);
            if (done === 1'b1) begin
                lat = n;
                break;
            end
            if (count !== held) stable = 1'b0;
            @(negedge clk);
        end
        start = 1'b0;
        got_cnt = int'(count);
        got_ovf = int'(overflow);
        if (inj_done) start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("done_one_cycle", done, 0);
        check("idle_busy", busy, 0);
    endtask

    function automatic int model_cnt(input int p);
        int e;
        e = W / p;
        return (e > CMAX) ? CMAX : e;
    endfunction

    function automatic int model_ovf(input int p);
        return ((W / p) > CMAX) ? 1 : 0;
    endfunction

    initial begin
        int c, o, lat, en, bz, e;
        bit st, seen;
        int pers[8];
        pers = '{2, 4, 5, 10, 20, 25, 50, 100};

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ro_enable", ro_enable, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_count", count, 0);
        check("rst_overflow", overflow, 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        mode = 0; per = 10; ph = $urandom_range(0, 9);
        measure(0, 0, c, o, lat, en, bz, st);
        check("nom_latency", lat, S + W + 1);
        check("nom_enable_cycles", en, S + W);
        check("nom_busy_cycles", bz, S + W + 1);
        check("nom_count", c, 10);
        check("nom_overflow", o, 0);

        mode = 2; lvl = 1'b0;
        measure(0, 0, c, o, lat, en, bz, st);
        check("idle0_count", c, 0);
        check("idle0_overflow", o, 0);
        lvl = 1'b1;
        measure(0, 0, c, o, lat, en, bz, st);
        check("idle1_count", c, 0);
        check("idle1_overflow", o, 0);

        mode = 0; per = 4; ph = $urandom_range(0, 3);
        measure(0, 0, c, o, lat, en, bz, st);
        check("sat_count", c, CMAX);
        check("sat_overflow", o, 1);
        per = 10;
        measure(0, 0, c, o, lat, en, bz, st);
        check("post_sat_count", c, 10);
        check("post_sat_overflow", o, 0);

        ph = $urandom_range(0, 9);
        measure(1, 1, c, o, lat, en, bz, st);
        check("ign_latency", lat, S + W + 1);
        check("ign_count", c, 10);
        check("ign_stable", st, 1);
        measure(0, 0, c, o, lat, en, bz, st);
        check("restart_latency", lat, S + W + 1);
        check("restart_count", c, 10);

        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (S + 39) @(negedge clk);
        check("pre_rst_enable", ro_enable, 1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_ro_enable", ro_enable, 0);
        check("arst_busy", busy, 0);
        check("arst_count", count, 0);
        seen = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (done !== 1'b0) seen = 1'b1;
        end
        rst_n = 1'b1;
        for (int i = 0; i < 150; i++) begin
            @(negedge clk);
            if (done !== 1'b0) seen = 1'b1;
        end
        check("arst_no_done", seen, 0);
        measure(0, 0, c, o, lat, en, bz, st);
        check("post_rst_count", c, 10);
        check("post_rst_latency", lat, S + W + 1);

        for (int i = 0; i < 8; i++) begin
            per = pers[$urandom_range(0, 7)];
            ph = $urandom_range(0, per - 1);
            measure(0, 0, c, o, lat, en, bz, st);
            check($sformatf("rnd_count_p%0d", per), c, model_cnt(per));
            check($sformatf("rnd_ovf_p%0d", per), o, model_ovf(per));
        end

        mode = 1;
        for (int i = 0; i < 50; i++) begin
            measure(0, 0, c, o, lat, en, bz, st);
            e = (c == 9 || c == 10) ? 1 : 0;
            if (e == 0)
                $display("async measurement %0d returned %0d", i, c);
            check("async_count_in_range", e, 1);
            check("async_overflow", o, 0);
            check("async_stable", st, 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
